// File: rtl/xy_input_buffer.sv
// Per-port packet buffer for the XY mesh switch: circular FIFO feeding a
// registered output stage that carries the packet plus the router's port select.
module xy_input_buffer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int PACKET_ADDR_X_W = 4,
  parameter int PACKET_ADDR_Y_W = 4,
  parameter int DATA_W          = 8,
  parameter int OUTPUT_N_W      = 3,
  localparam int PACKET_W       = PACKET_ADDR_X_W + PACKET_ADDR_Y_W + DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [PACKET_W-1:0]        in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [PACKET_ADDR_X_W-1:0] x_addr_o,
  output logic [PACKET_ADDR_Y_W-1:0] y_addr_o,
  input  logic [OUTPUT_N_W-1:0]      mux_out_sel_i,
  output logic [PACKET_W-1:0]        out_data_o,
  output logic [OUTPUT_N_W-1:0]      out_sel_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PACKET_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PACKET_W-1:0]   out_data_q, out_data_d;
  logic [OUTPUT_N_W-1:0] out_sel_q, out_sel_d;
  logic                  out_valid_q, out_valid_d;

  logic                  empty, full, push, load;
  logic [PACKET_W-1:0]   head;

  // Extra pointer MSB is a wrap bit: same index with different wrap means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                 (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;
  assign load       = !empty && (!out_valid_q || out_ready_i);

  assign head     = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign x_addr_o = head[PACKET_W-1 -: PACKET_ADDR_X_W];
  assign y_addr_o = head[DATA_W +: PACKET_ADDR_Y_W];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(load);
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = head;
      out_sel_d   = mux_out_sel_i;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      // Not loading while the consumer is ready implies the FIFO is empty.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: storage has no reset; pointers clearing makes old entries
  // unreachable, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= in_data_i;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;
  assign out_valid_o = out_valid_q;

endmodule
